// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver: start/data/stop framing with frame error and overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and a parity_err pulse.
`timescale 1ns/1ps
module uart_rx_os16 #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tick,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic                 sync1_q, rxs_q;
  logic [2:0]           state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 stop_good, stop_bad, load;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
  logic                 par_ok;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d    = S_START;
            tick_cnt_d = 4'd0;
          end
        end
        S_START: begin
          if (tick_cnt_q == 4'd7) begin
            // Line still low at mid-start: genuine start bit, otherwise a glitch.
            if (!rxs_q) begin
              state_d    = S_DATA;
              tick_cnt_d = 4'd0;
              bit_cnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            par_bit_d = rxs_q;
            state_d   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          // Leave at mid-stop so a following start edge is not missed.
          if (tick_cnt_q == 4'd15) begin
            state_d   = S_IDLE;
            stop_good = rxs_q;
            stop_bad  = ~rxs_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
`ifdef UART_RX_PARITY_EN
    par_ok       = ~(^shift_q ^ par_bit_q);
    parity_err_d = (stop_good | stop_bad) & ~par_ok;
    load         = stop_good & par_ok;
`else
    load         = stop_good;
`endif
    rx_data_d   = load ? shift_q : rx_data_q;
    rx_valid_d  = load | (rx_valid_q & ~rd_ack);
    overrun_d   = load & rx_valid_q & ~rd_ack;
    frame_err_d = stop_bad;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q      <= rxd;
      rxs_q        <= sync1_q;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 (default 8N1 build) with a compressed tick divider.
`timescale 1ns/1ps
module tb_uart_rx_os16;
  localparam int P = 8;  // clk cycles per 16x tick

  logic       clk = 1'b0, rstn = 1'b0, tick = 1'b0, rxd = 1'b1, rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0, n_fail = 0;
  int tdiv = 0, fe_cycles = 0, ov_cycles = 0, valid_rises = 0;
  logic valid_prev = 1'b0, tick_at_edge = 1'b0, last_rise_tick = 1'b0;
  int fe0, ov0, vr0;

  uart_rx_os16 #(.DATA_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .rxd(rxd), .rd_ack(rd_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tdiv <= (tdiv == P - 1) ? 0 : tdiv + 1;
    tick <= (tdiv == P - 1);
  end

  always @(posedge clk) tick_at_edge <= tick;

  always @(negedge clk) begin
    fe_cycles <= fe_cycles + (frame_err ? 1 : 0);
    ov_cycles <= ov_cycles + (overrun ? 1 : 0);
    if (rx_valid && !valid_prev) begin
      valid_rises    <= valid_rises + 1;
      last_rise_tick <= tick_at_edge;
    end
    valid_prev <= rx_valid;
  end

  task automatic wait_tick();
    do @(posedge clk); while (tick !== 1'b1);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic snap();
    fe0 = fe_cycles; ov0 = ov_cycles; vr0 = valid_rises;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    wait_tick();
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_ticks(16);
    end
    rxd = stop_bit;
    wait_ticks(16);
    rxd = 1'b1;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rstn = 1'b1;
    wait_ticks(4);
    $display("test_reset done");
  endtask

  task automatic test_frame_55();
    snap();
    send_frame(8'h55, 1'b1);
    wait_ticks(2);
    n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL f55_data: got %h expected 55", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL f55_valid: got %b expected 1", rx_valid); end
    n_checks++; if (valid_rises - vr0 !== 1) begin n_fail++; $display("FAIL f55_rises: got %0d expected 1", valid_rises - vr0); end
    n_checks++; if (last_rise_tick !== 1'b1) begin n_fail++; $display("FAIL f55_tick_timing: got %b expected 1", last_rise_tick); end
    n_checks++; if (fe_cycles - fe0 !== 0) begin n_fail++; $display("FAIL f55_frame_err: got %0d expected 0", fe_cycles - fe0); end
    n_checks++; if (ov_cycles - ov0 !== 0) begin n_fail++; $display("FAIL f55_overrun: got %0d expected 0", ov_cycles - ov0); end
    ack();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL f55_ack_clear: got %b expected 0", rx_valid); end
    ack();
    n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h55) begin n_fail++; $display("FAIL f55_idle_ack: got valid=%b data=%h expected 0/55", rx_valid, rx_data); end
    $display("test_frame_55 done: data=%h", rx_data);
  endtask

  task automatic test_glitch();
    snap();
    wait_tick();
    rxd = 1'b0;
    wait_ticks(5);
    rxd = 1'b1;
    wait_ticks(20);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
    n_checks++; if (valid_rises - vr0 !== 0) begin n_fail++; $display("FAIL glitch_rises: got %0d expected 0", valid_rises - vr0); end
    n_checks++; if (fe_cycles - fe0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cycles - fe0); end
    n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL glitch_data: got %h expected 55", rx_data); end
    $display("test_glitch done");
  endtask

  task automatic test_frame_err();
    snap();
    send_frame(8'hA3, 1'b0);
    wait_ticks(12);
    n_checks++; if (fe_cycles - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles expected 1", fe_cycles - fe0); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b expected 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL ferr_data: got %h expected 55", rx_data); end
    n_checks++; if (valid_rises - vr0 !== 0) begin n_fail++; $display("FAIL ferr_rises: got %0d expected 0", valid_rises - vr0); end
    $display("test_frame_err done");
  endtask

  task automatic test_back_to_back();
    snap();
    send_frame(8'h12, 1'b1);
    n_checks++; if (rx_data !== 8'h12 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got data=%h valid=%b expected 12/1", rx_data, rx_valid); end
    send_frame(8'h34, 1'b1);
    wait_ticks(2);
    n_checks++; if (rx_data !== 8'h34) begin n_fail++; $display("FAIL b2b_data: got %h expected 34", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
    n_checks++; if (ov_cycles - ov0 !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected 1", ov_cycles - ov0); end
    n_checks++; if (fe_cycles - fe0 !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d expected 0", fe_cycles - fe0); end
    ack();
    $display("test_back_to_back done: data=%h", rx_data);
  endtask

  task automatic test_ack_on_completion();
    send_frame(8'h12, 1'b1);
    snap();
    // 0x34 sent by hand so rd_ack lands exactly on the mid-stop tick edge.
    wait_tick();
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = (i == 2 || i == 4 || i == 5) ? 1'b1 : 1'b0;
      wait_ticks(16);
    end
    rxd = 1'b1;
    wait_ticks(8);
    repeat (P - 1) @(posedge clk);
    #1;
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
    wait_ticks(4);
    n_checks++; if (rx_data !== 8'h34) begin n_fail++; $display("FAIL ackc_data: got %h expected 34", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ackc_valid: got %b expected 1", rx_valid); end
    n_checks++; if (ov_cycles - ov0 !== 0) begin n_fail++; $display("FAIL ackc_overrun: got %0d expected 0", ov_cycles - ov0); end
    n_checks++; if (valid_rises - vr0 !== 0) begin n_fail++; $display("FAIL ackc_valid_gap: got %0d rises expected 0", valid_rises - vr0); end
    $display("test_ack_on_completion done: data=%h", rx_data);
  endtask

  task automatic test_reset_midframe();
    wait_tick();
    rxd = 1'b0;
    wait_ticks(16);
    rxd = 1'b1;
    wait_ticks(48);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_async_data: got %h expected 00", rx_data); end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    snap();
    wait_ticks(100);
    n_checks++; if (valid_rises - vr0 !== 0) begin n_fail++; $display("FAIL rst_spurious_valid: got %0d expected 0", valid_rises - vr0); end
    n_checks++; if (fe_cycles - fe0 !== 0) begin n_fail++; $display("FAIL rst_spurious_ferr: got %0d expected 0", fe_cycles - fe0); end
    n_checks++; if (ov_cycles - ov0 !== 0) begin n_fail++; $display("FAIL rst_spurious_ovr: got %0d expected 0", ov_cycles - ov0); end
    send_frame(8'h0F, 1'b1);
    wait_ticks(2);
    n_checks++; if (rx_data !== 8'h0F) begin n_fail++; $display("FAIL rst_next_data: got %h expected 0f", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rst_next_valid: got %b expected 1", rx_valid); end
    n_checks++; if (fe_cycles - fe0 !== 0 || ov_cycles - ov0 !== 0) begin n_fail++; $display("FAIL rst_next_flags: got ferr=%0d ovr=%0d expected 0/0", fe_cycles - fe0, ov_cycles - ov0); end
    $display("test_reset_midframe done: data=%h", rx_data);
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ack_on_completion();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
